// File: rtl/f_npc_ctrl_pkg.sv
// Shared encodings and default addresses for the fetch next-PC controller.
package f_npc_ctrl_pkg;

  localparam logic [1:0] NPC_NONE = 2'd0;
  localparam logic [1:0] NPC_J    = 2'd1;
  localparam logic [1:0] NPC_JR   = 2'd2;

  // Ordered so a numerically larger kind may overwrite a smaller one.
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_BR   = 2'd1,
    PEND_ERET = 2'd2,
    PEND_EXC  = 2'd3
  } pend_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/f_npc_target.sv
// Branch, j and jr target computation for the D-stage instruction.
module f_npc_target (
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs,
  output logic [31:0] br_tgt,
  output logic [31:0] j_tgt,
  output logic [31:0] jr_tgt
);

  logic [31:0] pc4;

  assign pc4    = d_pc + 32'd4;
  assign br_tgt = pc4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign j_tgt  = {pc4[31:28], d_imm26, 2'b00};
  assign jr_tgt = d_rs;

endmodule

// File: rtl/f_npc_ctrl.sv
// Fetch PC register, one-entry redirect holding register and imem handshake.
import f_npc_ctrl_pkg::*;

module f_npc_ctrl #(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        D_brValid,
  input  logic        D_isBr,
  input  logic [1:0]  D_jOp,
  input  logic [31:0] D_pc,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_rs,
  input  logic        excReq,
  input  logic        eretReq,
  input  logic [31:0] epc,
  output logic        F_req,
  output logic [31:0] F_pc,
  input  logic        F_ack,
  output logic        F_valid,
  output logic        F_kill
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        req_q, req_d;
  pend_e       kind_q, kind_d;

  logic [31:0] br_tgt, j_tgt, jr_tgt;
  logic [31:0] d_tgt, new_tgt;
  pend_e       new_kind;
  logic        ack, d_redir;

  f_npc_target u_tgt (
    .d_pc    (D_pc),
    .d_imm16 (D_imm16),
    .d_imm26 (D_imm26),
    .d_rs    (D_rs),
    .br_tgt  (br_tgt),
    .j_tgt   (j_tgt),
    .jr_tgt  (jr_tgt)
  );

  assign ack     = req_q & F_ack;
  assign d_redir = !stall &&
                   ((D_brValid && D_isBr) || D_jOp != NPC_NONE);

  always_comb begin
    unique case (D_jOp)
      NPC_J:   d_tgt = j_tgt;
      NPC_JR:  d_tgt = jr_tgt;
      default: d_tgt = br_tgt;
    endcase
  end

  // Highest-ranked redirect arriving this cycle; exc beats eret.
  always_comb begin
    new_kind = PEND_NONE;
    new_tgt  = d_tgt;
    if (excReq) begin
      new_kind = PEND_EXC;
      new_tgt  = EXC_VEC;
    end else if (eretReq) begin
      new_kind = PEND_ERET;
      new_tgt  = epc;
    end else if (d_redir) begin
      new_kind = PEND_BR;
    end
  end

  always_comb begin
    pc_d   = pc_q;
    tgt_d  = tgt_q;
    kind_d = kind_q;
    req_d  = 1'b1;
    if (ack) begin
      if (excReq || eretReq) begin
        pc_d   = new_tgt;
        kind_d = PEND_NONE;
      end else if (!stall) begin
        kind_d = PEND_NONE;
        if (kind_q != PEND_NONE)
          pc_d = tgt_q;
        else if (d_redir)
          pc_d = d_tgt;
        else
          pc_d = pc_q + 32'd4;
      end
    end else if (req_q && new_kind != PEND_NONE &&
                 new_kind >= kind_q) begin
      kind_d = new_kind;
      tgt_d  = new_tgt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      tgt_q  <= '0;
      kind_q <= PEND_NONE;
      req_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      tgt_q  <= tgt_d;
      kind_q <= kind_d;
      req_q  <= req_d;
    end
  end

  assign F_req   = req_q;
  assign F_pc    = pc_q;
  assign F_valid = ack && !stall;
  assign F_kill  = F_valid &&
                   (excReq || eretReq ||
                    kind_q == PEND_EXC || kind_q == PEND_ERET);

endmodule

// File: tb/tb_f_npc_ctrl.sv
// Directed and random checks of f_npc_ctrl against a queue-based model.
module tb_f_npc_ctrl;

  localparam logic [31:0] RPC  = 32'h0000_3000;
  localparam logic [31:0] EVEC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        D_brValid = 1'b0;
  logic        D_isBr = 1'b0;
  logic [1:0]  D_jOp = 2'd0;
  logic [31:0] D_pc = '0;
  logic [15:0] D_imm16 = '0;
  logic [25:0] D_imm26 = '0;
  logic [31:0] D_rs = '0;
  logic        excReq = 1'b0;
  logic        eretReq = 1'b0;
  logic [31:0] epc = '0;
  logic        F_ack = 1'b0;
  logic        F_req, F_valid, F_kill;
  logic [31:0] F_pc;

  int errs = 0;
  int checks = 0;

  f_npc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .D_brValid (D_brValid),
    .D_isBr    (D_isBr),
    .D_jOp     (D_jOp),
    .D_pc      (D_pc),
    .D_imm16   (D_imm16),
    .D_imm26   (D_imm26),
    .D_rs      (D_rs),
    .excReq    (excReq),
    .eretReq   (eretReq),
    .epc       (epc),
    .F_req     (F_req),
    .F_pc      (F_pc),
    .F_ack     (F_ack),
    .F_valid   (F_valid),
    .F_kill    (F_kill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_d();
    D_brValid = 1'b0;
    D_isBr    = 1'b0;
    D_jOp     = 2'd0;
  endtask

  // Model: outstanding redirects are kept as a list; the one used
  // is the highest-ranked, latest among equals.
  typedef struct {
    int          rank;
    logic [31:0] tgt;
  } red_t;

  red_t        pq[$];
  logic [31:0] m_pc = RPC;
  bit          m_req = 0;
  bit          c_ack, c_dred, c_val, c_kill;
  int          c_best, c_off;
  logic [31:0] c_bt, c_dt, c_pc4;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_pc", F_pc, RPC);
      chk("rst_req", {31'd0, F_req}, 32'd0);
      chk("rst_valid", {31'd0, F_valid}, 32'd0);
      chk("rst_kill", {31'd0, F_kill}, 32'd0);
      m_pc  = RPC;
      m_req = 0;
      pq.delete();
    end else begin
      c_best = -1;
      c_bt   = '0;
      foreach (pq[i])
        if (pq[i].rank >= c_best) begin
          c_best = pq[i].rank;
          c_bt   = pq[i].tgt;
        end
      c_pc4  = D_pc + 32'd4;
      c_off  = $signed(D_imm16);
      c_dred = !stall && ((D_brValid && D_isBr) || D_jOp != 2'd0);
      if (D_jOp == 2'd1)
        c_dt = (c_pc4 & 32'hF000_0000) | ({6'd0, D_imm26} << 2);
      else if (D_jOp == 2'd2)
        c_dt = D_rs;
      else
        c_dt = c_pc4 + 32'(c_off * 4);
      c_ack  = m_req && F_ack;
      c_val  = c_ack && !stall;
      c_kill = c_val && (excReq || eretReq || c_best >= 2);
      chk("pc", F_pc, m_pc);
      chk("req", {31'd0, F_req}, {31'd0, m_req});
      chk("valid", {31'd0, F_valid}, {31'd0, c_val});
      chk("kill", {31'd0, F_kill}, {31'd0, c_kill});
      if (!m_req) begin
        m_req = 1;
      end else if (c_ack) begin
        if (excReq) begin
          m_pc = EVEC;
          pq.delete();
        end else if (eretReq) begin
          m_pc = epc;
          pq.delete();
        end else if (!stall) begin
          if (pq.size() != 0) m_pc = c_bt;
          else if (c_dred)    m_pc = c_dt;
          else                m_pc = m_pc + 32'd4;
          pq.delete();
        end
      end else begin
        if (excReq)       pq.push_back('{3, EVEC});
        else if (eretReq) pq.push_back('{2, epc});
        else if (c_dred)  pq.push_back('{1, c_dt});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    step();
    chk("lit_rst_pc", F_pc, RPC);
    chk("lit_rst_req", {31'd0, F_req}, 32'd0);
    reset = 1'b0;
    F_ack = 1'b1;
    step();
    chk("lit_req_up", {31'd0, F_req}, 32'd1);
    chk("lit_pc0", F_pc, 32'h3000);
    #3 chk("lit_valid0", {31'd0, F_valid}, 32'd1);
    step();
    chk("lit_pc1", F_pc, 32'h3004);
    step();
    chk("lit_pc2", F_pc, 32'h3008);
    // taken backward branch
    D_pc = 32'h3004; D_brValid = 1'b1; D_isBr = 1'b1;
    D_imm16 = 16'hFFFE;
    #3 chk("lit_br_kill", {31'd0, F_kill}, 32'd0);
    step();
    chk("lit_br_pc", F_pc, 32'h3000);
    // j while ack is withheld
    clr_d();
    D_jOp = 2'd1; D_pc = 32'h3010; D_imm26 = 26'h0000C40;
    F_ack = 1'b0;
    step();
    clr_d();
    chk("lit_j_hold0", F_pc, 32'h3000);
    step();
    step();
    chk("lit_j_hold2", F_pc, 32'h3000);
    F_ack = 1'b1;
    #3 chk("lit_j_kill", {31'd0, F_kill}, 32'd0);
    step();
    chk("lit_j_pc", F_pc, 32'h3100);
    // pending branch overwritten by exception
    F_ack = 1'b0;
    D_brValid = 1'b1; D_isBr = 1'b1; D_pc = 32'h3100;
    D_imm16 = 16'hFFFF;
    step();
    clr_d();
    excReq = 1'b1;
    step();
    excReq = 1'b0;
    F_ack = 1'b1;
    #3 chk("lit_exc_kill", {31'd0, F_kill}, 32'd1);
    step();
    chk("lit_exc_pc", F_pc, EVEC);
    // stall holds PC while jr waits
    stall = 1'b1; D_jOp = 2'd2; D_rs = 32'h0000_5000;
    #3 chk("lit_stall_valid", {31'd0, F_valid}, 32'd0);
    step();
    chk("lit_stall_pc", F_pc, EVEC);
    stall = 1'b0;
    step();
    chk("lit_jr_pc", F_pc, 32'h0000_5000);
    clr_d();
    // reset with exception pending
    F_ack = 1'b0;
    excReq = 1'b1;
    step();
    excReq = 1'b0;
    #2 reset = 1'b1;
    #1 chk("lit_mid_rst_pc", F_pc, RPC);
    chk("lit_mid_rst_req", {31'd0, F_req}, 32'd0);
    F_ack = 1'b1;
    step();
    reset = 1'b0;
    #1 chk("lit_late_ack", {31'd0, F_valid}, 32'd0);
    step();
    chk("lit_rerq", {31'd0, F_req}, 32'd1);
    step();
    chk("lit_pend_clr", F_pc, 32'h3004);

    repeat (3000) begin
      step();
      reset     = ($urandom_range(0, 199) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      F_ack     = ($urandom_range(0, 9) < 6);
      excReq    = ($urandom_range(0, 15) == 0);
      eretReq   = ($urandom_range(0, 15) == 0);
      D_brValid = ($urandom_range(0, 2) == 0);
      D_isBr    = ($urandom_range(0, 1) == 1);
      D_jOp     = ($urandom_range(0, 5) == 0) ?
                  2'($urandom_range(1, 2)) : 2'd0;
      D_pc      = $urandom & 32'hFFFF_FFFC;
      D_imm16   = 16'($urandom);
      D_imm26   = 26'($urandom);
      D_rs      = $urandom;
      epc       = $urandom;
    end
    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
